// File: rtl/debug_uart_tx_if.sv
// Debug-controller side of the UART transmitter: transmit request, frame payload and status.
interface debug_uart_tx_if;
    logic        tx_flag;
    logic [2:0]  mode;
    logic [31:0] data_internal;
    logic        doneSending;
    logic        busy;

    modport master (
        output tx_flag,
        output mode,
        output data_internal,
        input  doneSending,
        input  busy
    );

    modport slave (
        input  tx_flag,
        input  mode,
        input  data_internal,
        output doneSending,
        output busy
    );
endinterface

// File: rtl/debug_uart_tx.sv
// 8N1 UART transmitter for debug replies: one header byte carrying the mode, then the
// 32-bit word MSB byte first; pulses doneSending once the last stop bit is on the line.
module debug_uart_tx #(
    parameter int unsigned freq = 50000000,
    parameter int unsigned baud = 115200
) (
    input  logic           CLK,
    input  logic           RST,
    debug_uart_tx_if.slave dbg,
    output logic           tx_serial
);

    localparam int unsigned CLKS_PER_BIT = freq / baud;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int unsigned FRAME_W      = 40;
    localparam int unsigned IDX_W        = 3;
    localparam logic [4:0]  HDR_TAG      = 5'b10100;

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("debug_uart_tx: freq/baud must be at least 2 clocks per bit");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        DONE     = 3'd4,
        WAIT_LOW = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   clk_cnt, clk_cnt_n;
    logic [IDX_W-1:0]   bit_idx, bit_idx_n;
    logic [IDX_W-1:0]   byte_idx, byte_idx_n;
    logic [FRAME_W-1:0] shreg, shreg_n;
    logic               tx_serial_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               last_tick_c;
    logic [CNT_W-1:0]   cnt_inc_c;

    assign dbg.busy        = busy_q;
    assign dbg.doneSending = done_q;

    // State, counters, frame shifter and the registered line/status outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shreg     <= '0;
            tx_serial <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_n;
            clk_cnt   <= clk_cnt_n;
            bit_idx   <= bit_idx_n;
            byte_idx  <= byte_idx_n;
            shreg     <= shreg_n;
            tx_serial <= tx_serial_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
        end
    end

    assign last_tick_c = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign cnt_inc_c   = last_tick_c ? '0 : clk_cnt + CNT_W'(1);

    // Line level is decoded from the current state, so the line trails the state by one
    // clock; busy is raised straight from the latch so it is visible right after it.
    always_comb begin
        state_n     = state;
        clk_cnt_n   = clk_cnt;
        bit_idx_n   = bit_idx;
        byte_idx_n  = byte_idx;
        shreg_n     = shreg;
        tx_serial_n = 1'b1;
        busy_n      = 1'b0;
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                if (dbg.tx_flag) begin
                    // Byte 0 sits in the low bits so the frame streams out by plain right shifts.
                    shreg_n    = {dbg.data_internal[7:0],   dbg.data_internal[15:8],
                                  dbg.data_internal[23:16], dbg.data_internal[31:24],
                                  HDR_TAG, dbg.mode};
                    clk_cnt_n  = '0;
                    bit_idx_n  = '0;
                    byte_idx_n = '0;
                    busy_n     = 1'b1;
                    state_n    = START;
                end
            end

            START: begin
                tx_serial_n = 1'b0;
                busy_n      = 1'b1;
                clk_cnt_n   = cnt_inc_c;
                if (last_tick_c) begin
                    state_n = DATA;
                end
            end

            DATA: begin
                tx_serial_n = shreg[0];
                busy_n      = 1'b1;
                clk_cnt_n   = cnt_inc_c;
                if (last_tick_c) begin
                    shreg_n   = shreg >> 1;
                    bit_idx_n = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_W'(7)) begin
                        bit_idx_n = '0;
                        state_n   = STOP;
                    end
                end
            end

            STOP: begin
                busy_n    = 1'b1;
                clk_cnt_n = cnt_inc_c;
                if (last_tick_c) begin
                    if (byte_idx < IDX_W'(4)) begin
                        byte_idx_n = byte_idx + IDX_W'(1);
                        state_n    = START;
                    end else begin
                        state_n    = DONE;
                    end
                end
            end

            DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b1;
                state_n = WAIT_LOW;
            end

            WAIT_LOW: begin
                if (!dbg.tx_flag) begin
                    state_n = IDLE;
                end
            end

            default: begin
                clk_cnt_n  = '0;
                bit_idx_n  = '0;
                byte_idx_n = '0;
                state_n    = IDLE;
            end
        endcase
    end

endmodule
